// File: rtl/ramp_adc_pkg.sv
// Shared types and constants for the ramp/R2R ADC sequencer.
package ramp_adc_pkg;

    localparam int SYNC_STAGES = 2;
    // One extra cycle lets the sample see a comparator that has crossed the synchronizer.
    localparam int MIN_SETTLE  = SYNC_STAGES + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } ramp_state_e;

endpackage : ramp_adc_pkg

// File: rtl/ramp_adc_controller_if.sv
// Request/result and DAC/comparator signals of the ramp ADC sequencer.
interface ramp_adc_controller_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             comp_async;
    logic [WIDTH-1:0] dac_code;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             over_range;

    modport master (
        output start,
        output comp_async,
        input  dac_code,
        input  busy,
        input  result,
        input  result_valid,
        input  over_range
    );

    modport slave (
        input  start,
        input  comp_async,
        output dac_code,
        output busy,
        output result,
        output result_valid,
        output over_range
    );
endinterface : ramp_adc_controller_if

// File: rtl/synchronizer.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
module synchronizer
    import ramp_adc_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q[0] <= '0;
        end else begin
            stage_q[0] <= d_i;
        end
    end

    for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                stage_q[gi] <= '0;
            end else begin
                stage_q[gi] <= stage_q[gi-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule : synchronizer

// File: rtl/ramp_adc_controller.sv
// Ramp ADC sequencer: steps the R2R code up from zero and captures the first comparator trip.
// Optional build macro RAMP_CONTINUOUS_EN: back-to-back conversions after the first start.
module ramp_adc_controller
    import ramp_adc_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ramp_adc_controller_if.slave  bus
);
    localparam int               CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] CODE_MAX = {WIDTH{1'b1}};

    localparam logic [1:0] ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] ST_SETTLE = 2'(SETTLE);
    localparam logic [1:0] ST_DONE   = 2'(DONE);

    if (SETTLE_CYCLES < MIN_SETTLE) begin : g_bad_settle
        $error("ramp_adc_controller: SETTLE_CYCLES (%0d) must be >= %0d", SETTLE_CYCLES, MIN_SETTLE);
    end

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dac_q, dac_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             over_q, over_d;
    logic             comp_sync;

    synchronizer #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) u_comp_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (bus.comp_async),
        .q_o     (comp_sync)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dac_d    = dac_q;
        result_d = result_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        over_d   = over_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SETTLE;
                    dac_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    // The comparator is only looked at on the last cycle of each hold.
                    cnt_d = '0;
                    if (comp_sync) begin
                        result_d = dac_q;
                        over_d   = 1'b0;
                        valid_d  = 1'b1;
                        state_d  = ST_DONE;
                    end else if (dac_q == CODE_MAX) begin
                        result_d = CODE_MAX;
                        over_d   = 1'b1;
                        valid_d  = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        dac_d = dac_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                dac_d = '0;
`ifdef RAMP_CONTINUOUS_EN
                state_d = ST_SETTLE;
                cnt_d   = '0;
`else
                state_d = ST_IDLE;
                busy_d  = 1'b0;
`endif
            end
            default: begin
                state_d = ST_IDLE;
                dac_d   = '0;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            dac_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dac_q    <= dac_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            over_q   <= over_d;
        end
    end

    assign bus.dac_code     = dac_q;
    assign bus.busy         = busy_q;
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.over_range   = over_q;

endmodule : ramp_adc_controller
